mult_seq_ctrl: RTL

FSM controller for the sequential shift-add multiplier.
- Sequences the external W-bit down counter: loads it, decrements it, reads its zero flag.
- Drives the operand, product and shift enables of the datapath. In the datapath the multiplicand shifts left, the multiplier shifts right, and the product accumulates.
- Exposes a start/busy/done/ack handshake to the requester.

---
 rtl/mult_seq_ctrl_if.sv | 33 +++
 rtl/mult_seq_ctrl.sv | 84 ++++++++
 2 files changed

// File: rtl/mult_seq_ctrl_if.sv
// Handshake and datapath-control bundle between the shift-add multiplier
// controller (master) and its requester/datapath/counter (slave).
interface mult_seq_ctrl_if #(
    parameter int W = 6
);
    logic         start;
    logic         ack;
    logic         mplier_lsb;
    logic         mplier_zero;
    logic         cnt_zero;
    logic         cnt_load;
    logic         cnt_dec;
    logic [W-1:0] cnt_init;
    logic         ld_operands;
    logic         clr_product;
    logic         add_en;
    logic         shift_en;
    logic         ready;
    logic         busy;
    logic         done;

    modport master (
        input  start, ack, mplier_lsb, mplier_zero, cnt_zero,
        output cnt_load, cnt_dec, cnt_init, ld_operands, clr_product,
               add_en, shift_en, ready, busy, done
    );

    modport slave (
        output start, ack, mplier_lsb, mplier_zero, cnt_zero,
        input  cnt_load, cnt_dec, cnt_init, ld_operands, clr_product,
               add_en, shift_en, ready, busy, done
    );
endinterface

// File: rtl/mult_seq_ctrl.sv
// FSM controller for the sequential shift-add multiplier.
// Optional macro MULT_SEQ_CTRL_EARLY_EXIT_EN: finish as soon as the multiplier empties.
module mult_seq_ctrl #(
    parameter int N = 32,
    parameter int W = 6
) (
    input logic             clk,
    input logic             rst,
    mult_seq_ctrl_if.master bus
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] TEST  = 3'd2;
    localparam logic [2:0] SHIFT = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0] state_reg;
    logic [2:0] state_next;
    logic       add_en_next;

`ifndef MULT_SEQ_CTRL_EARLY_EXIT_EN
    logic unused_mplier_zero;
    assign unused_mplier_zero = bus.mplier_zero;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // The counter is loaded with N in LOAD, so TEST sees N..1 on the
    // N iteration passes and zero on the final pass.
    always_comb begin
        state_next  = state_reg;
        add_en_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                state_next = TEST;
            end
            TEST: begin
                if (bus.cnt_zero) begin
                    state_next = DONE;
`ifdef MULT_SEQ_CTRL_EARLY_EXIT_EN
                end else if (bus.mplier_zero) begin
                    state_next = DONE;
`endif
                end else begin
                    add_en_next = bus.mplier_lsb;
                    state_next  = SHIFT;
                end
            end
            SHIFT: begin
                state_next = TEST;
            end
            DONE: begin
                if (bus.ack) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.cnt_init    = W'(N);
    assign bus.cnt_load    = (state_reg == LOAD);
    assign bus.ld_operands = (state_reg == LOAD);
    assign bus.clr_product = (state_reg == LOAD);
    assign bus.cnt_dec     = (state_reg == SHIFT);
    assign bus.shift_en    = (state_reg == SHIFT);
    assign bus.add_en      = add_en_next;
    assign bus.ready       = (state_reg == IDLE);
    assign bus.busy        = (state_reg == LOAD) || (state_reg == TEST) || (state_reg == SHIFT);
    assign bus.done        = (state_reg == DONE);
endmodule
